arc4_prga: RTL and testbench
============================

Name: arc4_prga

Overview:
- Keystream-generation and decrypt stage of the ARC4 pipeline; runs directly downstream of the key-scheduling stage.
- Consumes the 256-byte S array left in the shared S memory after KSA.
- Reads the length-prefixed ciphertext memory (CT) and writes the length-prefixed plaintext memory (PT).
- Started and monitored by the top-level controller through an en/rdy handshake.

Parameters:
- MSG_AW, 8, address width of CT/PT memories; the message length byte limits messages to 255 bytes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high when idle and able to accept en
- s_addr  out  8  S memory address
- s_rddata  in  8  S memory read data
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- ct_addr  out  MSG_AW  CT memory address
- ct_rddata  in  8  CT memory read data
- pt_addr  out  MSG_AW  PT memory address
- pt_wrdata  out  8  PT memory write data
- pt_wren  out  1  PT memory write enable

Behaviour:
- All memories have one-cycle read latency: an address driven in cycle n gives data usable in cycle n+1. Writes commit at the end of the cycle in which wren=1.
- Reset values (synchronous, active-high):
  - state=IDLE, rdy=1, all wren=0, all addresses/wrdata=0.
  - Internal registers i, j, k, len, si, sj, ct_byte are all 0.
  - Reset mid-operation returns to IDLE on the next edge. Memory contents are left as they are, and no further writes occur.
- Handshake:
  - en is accepted in the cycle where rdy=1 and en=1 (call this cycle 0). rdy drops in cycle 1.
  - en while busy is ignored.
  - rdy returns high in cycle 3+6*len.
- FSM, one state per cycle:
  - IDLE: rdy=1. On en: i<=1, j<=0, k<=1; go to LEN_RD.
  - LEN_RD: ct_addr=0.
  - LEN_WR: len<=ct_rddata; pt_addr=0, pt_wrdata=ct_rddata, pt_wren=1. Next is IDLE if ct_rddata==0, else RD_SI.
  - RD_SI: s_addr=i.
  - RD_SJ: si<=s_rddata; jn=(j+s_rddata) mod 256; j<=jn; s_addr=jn; ct_addr=k.
  - WR_SI: sj<=s_rddata; ct_byte<=ct_rddata; s_addr=i, s_wrdata=s_rddata, s_wren=1.
  - WR_SJ: s_addr=j, s_wrdata=si, s_wren=1.
  - RD_PAD: s_addr=(si+sj) mod 256.
  - WR_PT: pt_addr=k, pt_wrdata=s_rddata^ct_byte, pt_wren=1. Next is IDLE if k==len; otherwise k<=k+1, i<=i+1, go to RD_SI.
- Arithmetic: all index arithmetic is 8-bit modulo 256. j wraps freely; i never exceeds 255 because len is at most 255.
- Boundary cases:
  - i==j: WR_SI and WR_SJ both write the same value, so S is unchanged. This case needs no special handling.
  - len=0: only PT[0]=0 is written, and the block returns to rdy=1 in cycle 3.
  - Only one wren is high in any cycle. No output glitches on the registered state.

Decomposition:
- Package arc4_pkg holds:
  - typedef byte_t (logic [7:0]).
  - enum prga_state_t {IDLE, LEN_RD, LEN_WR, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, WR_PT}.
  - Constant PRGA_CYC_PER_BYTE=6.
- The same package is shared with the init and KSA stages.
- No sub-module: a single FSM plus datapath, with memories instantiated by the parent.

Test Plan:
- Identity S (S[x]=x), CT={03,41,42,43}, en pulse → PT={03,43,47,44}.
  - Afterwards S[1]=1, S[2]=3, S[3]=5, S[5]=2; all other entries unchanged.
  - rdy high exactly 21 cycles after acceptance.
- CT[0]=00, en → PT[0]=00, no S writes, rdy high in cycle 3.
- Identity S, first byte (i=j=1 case): CT={01,FF} → PT={01,FD}, S unchanged.
- en held high during the busy period of the first scenario → no restart; results identical to the first scenario; exactly one further run starts when rdy returns.
- rst asserted in cycle 10 of the first scenario → next cycle rdy=1 and all wren=0. Re-run after re-preloading identity S gives the first-scenario result.
- len=255 with random S and CT, compared against a software ARC4 model → all 255 PT bytes match; j wraps without error; rdy in cycle 1533.

Source files
------------

// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared types and constants for the ARC4 init, KSA and PRGA stages
package arc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_WR,
    RD_SI,
    RD_SJ,
    WR_SI,
    WR_SJ,
    RD_PAD,
    WR_PT
  } prga_state_t;

  localparam int PRGA_CYC_PER_BYTE = 6;

endpackage

// File: rtl/arc4_prga.sv
// rtl/arc4_prga.sv - ARC4 keystream generation and decrypt of a length-prefixed message
module arc4_prga
  import arc4_pkg::*;
#(
  parameter int MSG_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [MSG_AW-1:0] ct_addr,
  input  logic [7:0]        ct_rddata,
  output logic [MSG_AW-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren
);

  prga_state_t state_q, state_d;

  byte_t i_q, i_d;
  byte_t j_q, j_d;
  byte_t k_q, k_d;
  byte_t len_q, len_d;
  byte_t si_q, si_d;
  byte_t sj_q, sj_d;
  byte_t ct_byte_q, ct_byte_d;

  // New j is needed both as a register update and as the read address in RD_SJ.
  byte_t jn;
  byte_t pad_addr;

  assign jn       = j_q + s_rddata;
  assign pad_addr = si_q + sj_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      len_q     <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      ct_byte_q <= '0;
    end else begin
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      len_q     <= len_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      ct_byte_q <= ct_byte_d;
    end
  end

  // Next-state sequencing: one state per cycle, six cycles per message byte
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = LEN_RD;
      LEN_RD:  state_d = LEN_WR;
      LEN_WR:  state_d = (ct_rddata == 8'd0) ? IDLE : RD_SI;
      RD_SI:   state_d = RD_SJ;
      RD_SJ:   state_d = WR_SI;
      WR_SI:   state_d = WR_SJ;
      WR_SJ:   state_d = RD_PAD;
      RD_PAD:  state_d = WR_PT;
      WR_PT:   state_d = (k_q == len_q) ? IDLE : RD_SI;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: capture S[i], S[j] and the ciphertext byte, advance indices
  always_comb begin
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    ct_byte_d = ct_byte_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          i_d = 8'd1;
          j_d = 8'd0;
          k_d = 8'd1;
        end
      end
      LEN_WR: len_d = ct_rddata;
      RD_SJ: begin
        si_d = s_rddata;
        j_d  = jn;
      end
      WR_SI: begin
        sj_d      = s_rddata;
        ct_byte_d = ct_rddata;
      end
      WR_PT: begin
        if (k_q != len_q) begin
          k_d = k_q + 8'd1;
          i_d = i_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Memory-side outputs decoded from the registered state
  always_comb begin
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    unique case (state_q)
      IDLE:   rdy = 1'b1;
      LEN_RD: ct_addr = '0;
      LEN_WR: begin
        pt_addr   = '0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      RD_SI:  s_addr = i_q;
      RD_SJ: begin
        s_addr  = jn;
        ct_addr = MSG_AW'(k_q);
      end
      // S[j] read last cycle lands in S[i]; S[i] was captured in si_q.
      WR_SI: begin
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      WR_SJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
      end
      RD_PAD: s_addr = pad_addr;
      WR_PT: begin
        pt_addr   = MSG_AW'(k_q);
        pt_wrdata = s_rddata ^ ct_byte_q;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arc4_prga.sv
// tb/tb_arc4_prga.sv - randomized self-checking bench for arc4_prga against a software ARC4 model
module tb_arc4_prga;

  localparam int MSG_AW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              rdy;
  logic [7:0]        s_addr;
  logic [7:0]        s_rddata;
  logic [7:0]        s_wrdata;
  logic              s_wren;
  logic [MSG_AW-1:0] ct_addr;
  logic [7:0]        ct_rddata;
  logic [MSG_AW-1:0] pt_addr;
  logic [7:0]        pt_wrdata;
  logic              pt_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ref_s  [256];
  logic [7:0] ref_pt [256];

  int s_wr_cnt   = 0;
  int pt0_wr_cnt = 0;
  int multi_wren = 0;
  int n_cmp      = 0;
  int n_bad      = 0;

  arc4_prga #(.MSG_AW(MSG_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  always #5 clk = ~clk;

  // One-cycle-latency memories with write commit at the clock edge
  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
      s_wr_cnt      <= s_wr_cnt + 1;
    end
    if (pt_wren) begin
      pt_mem[pt_addr] <= pt_wrdata;
      if (pt_addr == 0) pt0_wr_cnt <= pt0_wr_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (s_wren && pt_wren) multi_wren <= multi_wren + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
  endtask

  task automatic load_random_perm();
    logic [7:0] t;
    int r;
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = int'($urandom_range(x, 0));
      t = s_mem[x]; s_mem[x] = s_mem[r]; s_mem[r] = t;
    end
  endtask

  task automatic clear_pt();
    for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;
  endtask

  task automatic load_ct_scenario1();
    ct_mem[0] = 8'h03; ct_mem[1] = 8'h41; ct_mem[2] = 8'h42; ct_mem[3] = 8'h43;
  endtask

  // Textbook ARC4 PRGA on a copy of S; ct_mem[0] holds the length.
  task automatic ref_prga();
    int len, i, j, t;
    for (int x = 0; x < 256; x++) ref_s[x] = s_mem[x];
    len = int'(ct_mem[0]);
    ref_pt[0] = ct_mem[0];
    j = 0;
    for (int k = 1; k <= len; k++) begin
      i = k % 256;
      j = (j + int'(ref_s[i])) % 256;
      t = int'(ref_s[i]); ref_s[i] = ref_s[j]; ref_s[j] = 8'(t);
      ref_pt[k] = ct_mem[k] ^ ref_s[(int'(ref_s[i]) + int'(ref_s[j])) % 256];
    end
  endtask

  // Pulse (or hold) en; returns the cycle index at which rdy is seen high again.
  task automatic run_prga(input bit hold_en, output int cyc);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!hold_en) en = 1'b0;
      if (rdy) break;
      if (cyc > 2000) begin
        check_eq("run_timeout", 32'(cyc), 32'd0);
        break;
      end
    end
  endtask

  task automatic check_vs_model(input string tag);
    int len, sdiff;
    len = int'(ct_mem[0]);
    for (int k = 0; k <= len; k++) check_eq($sformatf("%s_pt%0d", tag, k), 32'(pt_mem[k]), 32'(ref_pt[k]));
    sdiff = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) sdiff++;
    check_eq({tag, "_s_diffs"}, 32'(sdiff), 32'd0);
  endtask

  task automatic check_scenario1(input string tag);
    int other;
    check_eq({tag, "_pt0"}, 32'(pt_mem[0]), 32'h03);
    check_eq({tag, "_pt1"}, 32'(pt_mem[1]), 32'h43);
    check_eq({tag, "_pt2"}, 32'(pt_mem[2]), 32'h47);
    check_eq({tag, "_pt3"}, 32'(pt_mem[3]), 32'h44);
    check_eq({tag, "_s1"}, 32'(s_mem[1]), 32'd1);
    check_eq({tag, "_s2"}, 32'(s_mem[2]), 32'd3);
    check_eq({tag, "_s3"}, 32'(s_mem[3]), 32'd5);
    check_eq({tag, "_s5"}, 32'(s_mem[5]), 32'd2);
    other = 0;
    for (int x = 0; x < 256; x++)
      if (x != 2 && x != 3 && x != 5 && s_mem[x] !== 8'(x)) other++;
    check_eq({tag, "_s_other"}, 32'(other), 32'd0);
  endtask

  initial begin
    int cyc, sw0, p0, len, sdiff;
    rst = 1'b1;
    en  = 1'b0;
    for (int x = 0; x < 256; x++) begin
      s_mem[x] = 8'(x); ct_mem[x] = 8'h00; pt_mem[x] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdy", 32'(rdy), 32'd1);
    check_eq("rst_s_wren", 32'(s_wren), 32'd0);
    check_eq("rst_pt_wren", 32'(pt_wren), 32'd0);
    check_eq("rst_s_addr", 32'(s_addr), 32'd0);
    check_eq("rst_ct_addr", 32'(ct_addr), 32'd0);
    check_eq("rst_pt_addr", 32'(pt_addr), 32'd0);
    check_eq("rst_wrdata", {16'd0, s_wrdata, pt_wrdata}, 32'd0);
    rst = 1'b0;

    // Known-answer run on identity S
    load_identity(); load_ct_scenario1(); clear_pt();
    ref_prga();
    sw0 = s_wr_cnt;
    run_prga(1'b0, cyc);
    check_eq("s1_rdy_cycle", 32'(cyc), 32'd21);
    check_scenario1("s1");
    check_vs_model("s1_model");
    check_eq("s1_s_writes", 32'(s_wr_cnt - sw0), 32'd6);

    // Zero-length message
    load_identity(); ct_mem[0] = 8'h00; pt_mem[0] = 8'hAA;
    sw0 = s_wr_cnt;
    run_prga(1'b0, cyc);
    check_eq("len0_rdy_cycle", 32'(cyc), 32'd3);
    check_eq("len0_pt0", 32'(pt_mem[0]), 32'd0);
    check_eq("len0_s_writes", 32'(s_wr_cnt - sw0), 32'd0);

    // i==j on the first byte leaves S unchanged
    load_identity(); clear_pt(); ct_mem[0] = 8'h01; ct_mem[1] = 8'hFF;
    run_prga(1'b0, cyc);
    check_eq("ieqj_pt0", 32'(pt_mem[0]), 32'h01);
    check_eq("ieqj_pt1", 32'(pt_mem[1]), 32'hFD);
    sdiff = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(x)) sdiff++;
    check_eq("ieqj_s_unchanged", 32'(sdiff), 32'd0);

    // en held through the busy period: exactly one extra run when rdy returns
    load_identity(); load_ct_scenario1(); clear_pt();
    p0 = pt0_wr_cnt;
    run_prga(1'b1, cyc);
    check_eq("hold_rdy_cycle", 32'(cyc), 32'd21);
    check_scenario1("hold");
    @(negedge clk);
    en = 1'b0;
    check_eq("hold_restarted", 32'(rdy), 32'd0);
    for (int n = 0; n < 100 && !rdy; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    check_eq("hold_run_count", 32'(pt0_wr_cnt - p0), 32'd2);

    // Reset in cycle 10 aborts the run cleanly
    load_identity(); load_ct_scenario1(); clear_pt();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      en = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_rdy", 32'(rdy), 32'd1);
    check_eq("abort_wren", {30'd0, s_wren, pt_wren}, 32'd0);
    sw0 = s_wr_cnt; p0 = pt0_wr_cnt;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("abort_no_writes", 32'((s_wr_cnt - sw0) + (pt0_wr_cnt - p0)), 32'd0);
    load_identity(); clear_pt();
    run_prga(1'b0, cyc);
    check_eq("rerun_rdy_cycle", 32'(cyc), 32'd21);
    check_scenario1("rerun");

    // Random S and CT at a few short lengths
    for (int t = 0; t < 4; t++) begin
      load_random_perm(); clear_pt();
      len = int'($urandom_range(20, 1));
      ct_mem[0] = 8'(len);
      for (int k = 1; k < 256; k++) ct_mem[k] = 8'($urandom);
      ref_prga();
      run_prga(1'b0, cyc);
      check_eq($sformatf("rnd%0d_rdy_cycle", t), 32'(cyc), 32'(3 + 6 * len));
      check_vs_model($sformatf("rnd%0d", t));
    end

    // Maximum length message, j wraps many times
    load_random_perm(); clear_pt();
    ct_mem[0] = 8'd255;
    for (int k = 1; k < 256; k++) ct_mem[k] = 8'($urandom);
    ref_prga();
    run_prga(1'b0, cyc);
    check_eq("max_rdy_cycle", 32'(cyc), 32'd1533);
    check_vs_model("max");

    check_eq("single_wren", 32'(multi_wren), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
